// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared definitions for the two-requester RAM port arbiter.
//   ADDR_W_DFLT / DATA_W_DFLT / RD_LAT_DFLT : default geometry and RAM read latency
//   req_id_t : requester index (two requesters -> one bit)
//   tag_t    : read-tracking pipeline entry (valid + requester id)
package ram_arb_pkg;

  localparam int ADDR_W_DFLT = 6;
  localparam int DATA_W_DFLT = 8;
  localparam int RD_LAT_DFLT = 2;

  typedef logic req_id_t;

  typedef struct packed {
    logic    vld;
    req_id_t id;
  } tag_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: request/response bundle between two requesters and the
// arbiter. Requester i occupies bit i of the 2-bit vectors and slice
// [i*W +: W] of the packed address/data vectors.
//   req_valid / req_ready : per-requester handshake (ready is one-hot or zero)
//   req_we                : 1 = write, 0 = read
//   req_addr / req_wdata  : per-requester address and write data
//   rsp_valid / rsp_data  : one-cycle read-data strobe and shared read data
// Modports: master = requester side, slave = arbiter side.
interface ram_port_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DFLT,
  parameter int DATA_W = DATA_W_DFLT
);

  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0]          req_we;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_wdata;
  logic [1:0]          rsp_valid;
  logic [DATA_W-1:0]   rsp_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/ram_arb_rr.sv
// ram_arb_rr: 2-way round-robin picker.
//   i_valid      : per-requester request valid
//   i_last_grant : requester granted most recently
//   o_grant      : one-hot grant (zero when nothing is valid)
// A lone requester always wins; on contention the requester that was not
// granted last wins.
module ram_arb_rr
  import ram_arb_pkg::*;
(
  input  logic [1:0] i_valid,
  input  req_id_t    i_last_grant,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    case (i_valid)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = i_last_grant ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one dual-port RAM (separate read and write ports,
// both clocked by clk) between two requesters.
//   clk, rst_n     : single clock, synchronous active-low reset
//   bus            : requester bundle (slave side)
//   ram_we, ram_write_addr, ram_data : RAM write port, one cycle after acceptance
//   ram_read_addr  : RAM read address, one cycle after acceptance, held otherwise
//   ram_q          : RAM read data, valid RD_LAT cycles after ram_read_addr
// At most one request is accepted per cycle. Each accepted read enters a
// 1+RD_LAT deep tag pipeline so its response strobe lines up with ram_q and
// responses come back in acceptance order.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DFLT,
  parameter int DATA_W = DATA_W_DFLT,
  parameter int RD_LAT = RD_LAT_DFLT
) (
  input  logic              clk,
  input  logic              rst_n,
  ram_port_arbiter_if.slave bus,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_write_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_read_addr,
  input  logic [DATA_W-1:0] ram_q
);

  localparam int NTAG = 1 + RD_LAT;

  logic [1:0]        w_grant;
  logic [1:0]        w_accept;
  logic              w_any;
  req_id_t           w_id;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_rsp_vld;

  req_id_t           r_last_grant;
  logic              r_we_p0;
  logic [ADDR_W-1:0] r_waddr_p0;
  logic [DATA_W-1:0] r_wdata_p0;
  logic [ADDR_W-1:0] r_raddr_p0;
  tag_t              r_tag_p [NTAG];

  ram_arb_rr u_rr (
    .i_valid      (bus.req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  // Ready is forced low during reset so nothing is accepted on a reset edge.
  assign bus.req_ready = rst_n ? w_grant : 2'b00;

  assign w_accept = bus.req_valid & bus.req_ready;
  assign w_any    = |w_accept;
  assign w_id     = w_accept[1];
  assign w_we     = bus.req_we[w_id];
  assign w_addr   = w_id ? bus.req_addr[2*ADDR_W-1 -: ADDR_W]
                         : bus.req_addr[ADDR_W-1:0];
  assign w_wdata  = w_id ? bus.req_wdata[2*DATA_W-1 -: DATA_W]
                         : bus.req_wdata[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_we_p0      <= 1'b0;
      r_waddr_p0   <= '0;
      r_wdata_p0   <= '0;
      r_raddr_p0   <= '0;
      for (int i = 0; i < NTAG; i++) begin
        r_tag_p[i] <= '{vld: 1'b0, id: 1'b0};
      end
    end else begin
      // p0: registered request drives the RAM ports
      r_we_p0 <= w_any & w_we;
      if (w_any) begin
        r_last_grant <= w_id;
        if (w_we) begin
          r_waddr_p0 <= w_addr;
          r_wdata_p0 <= w_wdata;
        end else begin
          r_raddr_p0 <= w_addr;
        end
      end
      r_tag_p[0].vld <= w_any & ~w_we;
      if (w_any) begin
        r_tag_p[0].id <= w_id;
      end
      // p1..pRD_LAT: tag follows the read through the RAM latency
      for (int i = 1; i < NTAG; i++) begin
        r_tag_p[i] <= r_tag_p[i-1];
      end
    end
  end

  assign ram_we         = r_we_p0;
  assign ram_write_addr = r_waddr_p0;
  assign ram_data       = r_wdata_p0;
  assign ram_read_addr  = r_raddr_p0;

  // Last tag stage coincides with ram_q for that read; gated by rst_n so no
  // strobe escapes while reset is asserted.
  assign w_rsp_vld     = rst_n & r_tag_p[NTAG-1].vld;
  assign bus.rsp_valid = w_rsp_vld ? (r_tag_p[NTAG-1].id ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_data  = w_rsp_vld ? ram_q : '0;

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameters SHALL be as listed (name, default, meaning):
  ADDR_W, 6, RAM address width (64 words)
  DATA_W, 8, RAM data width
  RD_LAT, 2, RAM read latency in clk cycles from ram_read_addr to valid ram_q
REQ-002 Ports SHALL be as listed (name, direction, width, meaning):
  clk  input  1  single clock; also drives RAM read_clk and write_clk
  rst_n  input  1  synchronous, active-low reset
  req_valid  input  2  per-requester request valid
  req_ready  output  2  per-requester accept, one-hot or zero
  req_we  input  2  per-requester op: 1 = write, 0 = read
  req_addr  input  2*ADDR_W  per-requester address, requester i at [i*ADDR_W +: ADDR_W]
  req_wdata  input  2*DATA_W  per-requester write data
  rsp_valid  output  2  per-requester read-data strobe, one cycle
  rsp_data  output  DATA_W  read data, valid when any rsp_valid bit set
  ram_we  output  1  RAM write enable
  ram_write_addr  output  ADDR_W  RAM write address
  ram_data  output  DATA_W  RAM write data
  ram_read_addr  output  ADDR_W  RAM read address
  ram_q  input  DATA_W  RAM read data
REQ-003 Clock and reset SHALL be exactly one clock, clk, and a synchronous active-low reset, rst_n.

Function
REQ-004 At most one request SHALL be accepted per cycle; acceptance = req_valid[i] && req_ready[i] at a rising clk edge.
REQ-005 req_ready SHALL be combinational from req_valid and the priority pointer; neither req_ready bit SHALL be set while rst_n = 0.
REQ-006 Arbitration SHALL be 2-way round-robin: one valid requester -> it is granted; both valid -> the requester not granted last is granted.
REQ-007 The priority pointer (last_grant) SHALL update only on acceptance.
REQ-008 On an accepted write, ram_we = 1, ram_write_addr, and ram_data SHALL be driven from the registered request in the cycle after acceptance, for exactly one cycle.
REQ-009 ram_we SHALL be 0 in every cycle without a registered write.
REQ-010 On an accepted read, ram_read_addr SHALL be driven from the registered request in the cycle after acceptance.
REQ-011 ram_read_addr SHALL hold its last value when no read is issued.
REQ-012 A tag pipeline of 1+RD_LAT stages (valid bit + requester id) SHALL track each read.
REQ-013 rsp_valid[id] SHALL pulse for one cycle exactly 1+RD_LAT cycles after acceptance (3 with defaults), with rsp_data = ram_q in that cycle.
REQ-014 Responses SHALL return in acceptance order.
REQ-015 A read may be accepted in any cycle; back-to-back reads SHALL yield back-to-back responses.
REQ-016 Read-after-write to the same address, accepted in consecutive cycles, SHALL return the newly written data.
REQ-017 There is no response backpressure; the requester SHALL take rsp_data in the cycle rsp_valid is asserted.
REQ-018 Requests that are not accepted SHALL NOT modify any state; a requester holds its request until ready.
REQ-019 Addresses SHALL use the full 0..2^ADDR_W-1 range with no wrap logic; address 63 is legal.

Reset
REQ-020 While rst_n = 0 at a clk edge, the block SHALL set: req_ready = 0, rsp_valid = 0, rsp_data = 0, ram_we = 0, ram_write_addr = 0, ram_data = 0, ram_read_addr = 0, all tag valids = 0, last_grant = 1 (requester 0 wins first).
REQ-021 Reset mid-operation SHALL drop every in-flight read (no rsp_valid after reset) and cancel any registered write not yet presented.
REQ-022 RAM contents are not cleared by reset.

Structure
REQ-023 Package ram_arb_pkg SHALL hold the ADDR_W, DATA_W, and RD_LAT defaults, the requester-id typedef (1 bit), and the tag-stage struct (valid, id).
REQ-024 Sub-module ram_arb_rr SHALL contain the 2-way round-robin picker (inputs valid[1:0], last_grant; outputs one-hot grant); all other logic stays in ram_port_arbiter.

Verification
REQ-025 The bench SHALL pair ram_port_arbiter with the dual-port RAM (both RAM clocks tied to clk) and cover:
  Req0 writes 0x00=AA, then reads 0x00 -> rsp_valid[0] exactly 3 cycles after read acceptance, rsp_data = AA.
  Both requesters hold valid for 4 cycles (R0 write 0x01=11, R1 write 0x02=22, ...) -> grants alternate 0,1,0,1; read-back returns 11 and 22.
  R1 writes 0x3F=55, and R0 reads 0x3F in the next cycle -> rsp_data = 55 to R0 only.
  R0 and R1 issue back-to-back reads of 0x00 and 0x3F -> consecutive rsp_valid pulses [0] then [1] with AA then 55.
  rst_n dropped 1 cycle after a read is accepted -> no rsp_valid afterwards; all outputs 0; the first grant after reset goes to R0.
  Only R1 valid for 5 cycles -> R1 granted every cycle; last_grant = 1.
